// File: rtl/rvr32_bru_if.sv
// Execute/fetch-facing signal bundle of the rvr32 branch resolution unit.
// master = execute/fetch side, slave = the resolution unit itself.
interface rvr32_bru_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        is_br;
   logic        is_jal;
   logic        is_jalr;
   logic        cmp_out;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_rd_we;
   logic [31:0] out_link;
   logic        out_misalign;
   logic [31:0] bht_pc;
   logic        bht_taken;

   modport master (
      output flush, in_valid, is_br, is_jal, is_jalr, cmp_out, pc, imm, rs1_data,
             pred_taken, pred_target, redirect_ready, bht_pc,
      input  in_ready, redirect_valid, redirect_pc, out_valid, out_rd_we, out_link,
             out_misalign, bht_taken
   );

   modport slave (
      input  flush, in_valid, is_br, is_jal, is_jalr, cmp_out, pc, imm, rs1_data,
             pred_taken, pred_target, redirect_ready, bht_pc,
      output in_ready, redirect_valid, redirect_pc, out_valid, out_rd_we, out_link,
             out_misalign, bht_taken
   );
endinterface

// File: rtl/rvr32_bru.sv
// Branch resolution unit: direction/target resolution, mispredict redirect, link value.
// Define RVR32_BHT_EN to build the 2-bit branch history table; otherwise bht_taken is 0.
module rvr32_bru #(
   parameter int          BHT_IDX_W   = 4,
   parameter logic [31:0] RST_PC_LINK = 32'h0
) (
   input logic        clk,
   input logic        rst_n,
   rvr32_bru_if.slave bus
);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] REDIRECT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        redirectValid_q, redirectValid_d;
   logic [31:0] redirectPc_q, redirectPc_d;
   logic        outValid_q, outValid_d;
   logic        outRdWe_q, outRdWe_d;
   logic        outMisalign_q, outMisalign_d;
   logic [31:0] outLink_q, outLink_d;

   logic        isJump;
   logic        taken;
   logic        misalign;
   logic        mispredict;
   logic        accept;
   logic        bhtWe;
   logic [31:0] pcPlus4;
   logic [31:0] brTarget;
   logic [31:0] jalrSum;
   logic [31:0] target;

   assign isJump     = bus.is_jal | bus.is_jalr;
   assign taken      = isJump | (bus.is_br & bus.cmp_out);
   assign pcPlus4    = bus.pc + 32'd4;
   assign brTarget   = bus.pc + bus.imm;
   assign jalrSum    = bus.rs1_data + bus.imm;
   assign target     = bus.is_jalr ? (jalrSum & ~32'h1) : brTarget;
   assign misalign   = taken & (target[1:0] != 2'b00);
   assign mispredict = (taken != bus.pred_taken) | (taken & (target != bus.pred_target));
   assign accept     = bus.in_valid & (state_q == IDLE) & ~bus.flush & (bus.is_br | isJump);
   // Misaligned taken branches must not train the predictor.
   assign bhtWe      = accept & bus.is_br & ~misalign;

   // flush outranks redirect_ready; a redirect is only raised from IDLE.
   always_comb begin
      state_d         = state_q;
      redirectValid_d = redirectValid_q;
      redirectPc_d    = redirectPc_q;
      if (bus.flush) begin
         state_d         = IDLE;
         redirectValid_d = 1'b0;
      end else if (state_q == REDIRECT) begin
         if (bus.redirect_ready) begin
            state_d         = IDLE;
            redirectValid_d = 1'b0;
         end
      end else if (accept && mispredict && !misalign) begin
         state_d         = REDIRECT;
         redirectValid_d = 1'b1;
         redirectPc_d    = taken ? target : pcPlus4;
      end
      outValid_d    = accept;
      outRdWe_d     = accept & isJump;
      outMisalign_d = accept & misalign;
      outLink_d     = accept ? pcPlus4 : outLink_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         redirectValid_q <= 1'b0;
         redirectPc_q    <= 32'h0;
         outValid_q      <= 1'b0;
         outRdWe_q       <= 1'b0;
         outMisalign_q   <= 1'b0;
         outLink_q       <= RST_PC_LINK;
      end else begin
         state_q         <= state_d;
         redirectValid_q <= redirectValid_d;
         redirectPc_q    <= redirectPc_d;
         outValid_q      <= outValid_d;
         outRdWe_q       <= outRdWe_d;
         outMisalign_q   <= outMisalign_d;
         outLink_q       <= outLink_d;
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.redirect_valid = redirectValid_q;
   assign bus.redirect_pc    = redirectPc_q;
   assign bus.out_valid      = outValid_q;
   assign bus.out_rd_we      = outRdWe_q;
   assign bus.out_link       = outLink_q;
   assign bus.out_misalign   = outMisalign_q;

`ifdef RVR32_BHT_EN
   localparam int BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           bht_q [BHT_N];
   logic [1:0]           bhtCtr_d;
   logic [BHT_IDX_W-1:0] wrIdx;
   logic [BHT_IDX_W-1:0] rdIdx;
   logic                 unusedBhtPc;

   assign wrIdx = bus.pc[BHT_IDX_W+1:2];
   assign rdIdx = bus.bht_pc[BHT_IDX_W+1:2];

   // Saturating 2-bit counter step for the entry being trained.
   always_comb begin
      bhtCtr_d = bht_q[wrIdx];
      if (taken && bht_q[wrIdx] != 2'b11) begin
         bhtCtr_d = bht_q[wrIdx] + 2'd1;
      end else if (!taken && bht_q[wrIdx] != 2'b00) begin
         bhtCtr_d = bht_q[wrIdx] - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (bhtWe) begin
         bht_q[wrIdx] <= bhtCtr_d;
      end
   end

   assign bus.bht_taken = bht_q[rdIdx][1];
   assign unusedBhtPc   = ^{bus.bht_pc[31:BHT_IDX_W+2], bus.bht_pc[1:0]};
`else
   logic unusedBhtPc;

   assign bus.bht_taken = 1'b0;
   assign unusedBhtPc   = ^{bus.bht_pc, bhtWe};
`endif

endmodule
